hps_pio_handshake: RTL and testbench
====================================

HPS_PIO_HANDSHAKE -- requirements
Module: hps_pio_handshake

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, output data width (legal 1..32).
REQ-002 SHALL have parameter TIMEOUT_WIDTH, default 16, timeout counter width (legal 1..32).
REQ-003 SHALL have port clk  input  1  single clock; all logic is rising-edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port address  input  3  Avalon-MM word address.
REQ-006 SHALL have port chipselect  input  1  Avalon-MM select.
REQ-007 SHALL have port write_n  input  1  Avalon-MM write strobe, active-low.
REQ-008 SHALL have port writedata  input  32  Avalon-MM write data.
REQ-009 SHALL have port readdata  output  32  combinational read mux on address, zero-extended.
REQ-010 SHALL have port out_data  output  DATA_WIDTH  data to fabric.
REQ-011 SHALL have port out_valid  output  1  data valid to fabric.
REQ-012 SHALL have port in_ready  input  1  fabric accept.

Function
REQ-013 SHALL decode a write as chipselect && !write_n; writes to unmapped addresses SHALL be ignored and read 0.
REQ-014 SHALL map registers: 0 DATA (R/W); 1 CTRL (bit0 GO write-only, bit1 AUTO R/W); 2 STATUS (bit0 BUSY RO, bit1 DONE, bit2 TMO, bit3 OVR; bits1-3 sticky, write-1-to-clear); 3 SET (write-1 sets DATA bits); 4 CLR (write-1 clears DATA bits); 5 TIMEOUT (R/W, TIMEOUT_WIDTH bits).
REQ-015 SHALL use an FSM with states IDLE and VALID; out_valid = (state == VALID); BUSY = out_valid.
REQ-016 SHALL launch (IDLE->VALID, next edge) on a CTRL write with writedata[0]=1, or on a DATA/SET/CLR write when AUTO=1.
REQ-017 SHALL, in VALID, complete the transfer on the first edge with in_ready=1: go to IDLE and set DONE.
REQ-018 SHALL load the timeout counter with TIMEOUT at launch and decrement it each VALID cycle; on reaching 0 with TIMEOUT!=0, go to IDLE and set TMO; TIMEOUT=0 SHALL disable timeout (wait indefinitely).
REQ-019 SHALL give in_ready priority over timeout when both occur on the same edge (DONE set, TMO not set).
REQ-020 SHALL hold out_data stable while VALID: DATA/SET/CLR/GO writes in VALID SHALL be discarded and set OVR.
REQ-021 SHALL truncate writedata to DATA_WIDTH for DATA/SET/CLR and to TIMEOUT_WIDTH for TIMEOUT.
REQ-022 SHALL let a write-1 clear of a sticky bit lose to a set event on the same edge (bit ends 1).
REQ-023 SHALL drive out_data = DATA register with no added latency.

Reset
REQ-024 SHALL, on reset_n=0, asynchronously force: state IDLE, out_valid 0, DATA 0, AUTO 0, TIMEOUT 0, counter 0, all STATUS bits 0 (IRQ_MASK 0, irq 0 when compiled in).
REQ-025 SHALL abort an in-flight transfer on reset without setting DONE or TMO.

Configuration
REQ-026 SHALL, with HPS_PIO_HANDSHAKE_IRQ_EN defined, add output irq (1 bit) and register 6 IRQ_MASK (bits1-3); irq = |(STATUS[3:1] & IRQ_MASK), registered (one-cycle latency).
REQ-027 SHALL, without HPS_PIO_HANDSHAKE_IRQ_EN, omit port irq; address 6 SHALL read 0 and ignore writes.

Structure
REQ-028 SHALL place register address constants, STATUS/CTRL bit indices and the FSM state typedef in package hps_pio_pkg.
REQ-029 SHALL implement the timeout down-counter (load, decrement, zero flag) as sub-module hps_pio_timeout_counter.

Verification
REQ-030 SHALL cover: write DATA=0xA5, GO; in_ready high 3 cycles later -> out_valid high exactly 3 cycles, out_data=0xA5, STATUS=0x2 after.
REQ-031 SHALL cover: TIMEOUT=4, GO, in_ready low -> out_valid drops after 4 VALID cycles, STATUS=0x4.
REQ-032 SHALL cover: TIMEOUT=4, in_ready rises on the expiry edge -> STATUS=0x2 (DONE only).
REQ-033 SHALL cover: AUTO=1, DATA=0x0F, SET 0xF0 while VALID -> OVR set, out_data stays 0x0F; after completion, CLR 0x01 relaunches with out_data=0x0E.
REQ-034 SHALL cover: reset_n low mid-VALID -> out_valid 0 immediately, all registers read 0.
REQ-035 SHALL cover (IRQ_EN): IRQ_MASK=0x2, complete a transfer -> irq rises one cycle after DONE; write STATUS=0x2 -> irq falls.

Source files
------------

// File: rtl/hps_pio_pkg.sv
// Shared constants for the HPS PIO handshake block: register map, bit positions, FSM state type.
package hps_pio_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_CTRL     = 3'd1;
  localparam logic [2:0] ADDR_STATUS   = 3'd2;
  localparam logic [2:0] ADDR_SET      = 3'd3;
  localparam logic [2:0] ADDR_CLR      = 3'd4;
  localparam logic [2:0] ADDR_TIMEOUT  = 3'd5;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd6;

  localparam int CTRL_GO   = 0;
  localparam int CTRL_AUTO = 1;

  localparam int STATUS_BUSY = 0;
  localparam int STATUS_DONE = 1;
  localparam int STATUS_TMO  = 2;
  localparam int STATUS_OVR  = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_VALID = 1'b1
  } state_t;

endpackage

// File: rtl/hps_pio_timeout_counter.sv
// Transfer timeout down-counter: loads at launch, counts down while valid, flags zero and last tick.
module hps_pio_timeout_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             last
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !zero) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);
  // A count of 1 means this decrement lands on 0; a zero load never reaches here, so it never expires.
  assign last = (count == WIDTH'(1));

endmodule

// File: rtl/hps_pio_handshake.sv
// Avalon-MM slave driving a valid/ready handshake to fabric, with optional timeout.
// Optional interrupt output and IRQ_MASK register when HPS_PIO_HANDSHAKE_IRQ_EN is defined.
//
// state    | meaning
// ST_IDLE  | no transfer pending; DATA/SET/CLR/GO writes accepted
// ST_VALID | out_valid high, out_data frozen, waiting for in_ready or timeout
module hps_pio_handshake
  import hps_pio_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  in_ready
`ifdef HPS_PIO_HANDSHAKE_IRQ_EN
  ,
  output logic                  irq
`endif
);

  state_t                   state_q;
  logic [DATA_WIDTH-1:0]    data_q;
  logic                     auto_q;
  logic [TIMEOUT_WIDTH-1:0] timeout_q;
  logic                     done_q;
  logic                     tmo_q;
  logic                     ovr_q;

  logic                     wr;
  logic                     wr_data;
  logic                     wr_ctrl;
  logic                     wr_status;
  logic                     wr_set;
  logic                     wr_clr;
  logic                     wr_timeout;
  logic                     data_wr_any;
  logic                     go;
  logic                     busy;
  logic                     launch;
  logic                     overrun;
  logic                     complete;
  logic                     expire;
  logic [DATA_WIDTH-1:0]    wd_data;
  logic [TIMEOUT_WIDTH-1:0] tmr_count;
  logic                     tmr_zero;
  logic                     tmr_last;
  logic                     unused_bits;

  assign wr          = chipselect && !write_n;
  assign wr_data     = wr && (address == ADDR_DATA);
  assign wr_ctrl     = wr && (address == ADDR_CTRL);
  assign wr_status   = wr && (address == ADDR_STATUS);
  assign wr_set      = wr && (address == ADDR_SET);
  assign wr_clr      = wr && (address == ADDR_CLR);
  assign wr_timeout  = wr && (address == ADDR_TIMEOUT);
  assign data_wr_any = wr_data || wr_set || wr_clr;
  assign go          = wr_ctrl && writedata[CTRL_GO];
  assign wd_data     = writedata[DATA_WIDTH-1:0];

  assign busy     = (state_q == ST_VALID);
  assign launch   = !busy && (go || (auto_q && data_wr_any));
  assign overrun  = busy && (data_wr_any || go);
  assign complete = busy && in_ready;
  // in_ready wins when it coincides with the expiry edge
  assign expire   = busy && !in_ready && tmr_last;

  hps_pio_timeout_counter #(
    .WIDTH(TIMEOUT_WIDTH)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (launch),
    .load_val(timeout_q),
    .dec     (busy),
    .count   (tmr_count),
    .zero    (tmr_zero),
    .last    (tmr_last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      data_q    <= '0;
      auto_q    <= 1'b0;
      timeout_q <= '0;
      done_q    <= 1'b0;
      tmo_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE:  if (launch) state_q <= ST_VALID;
        ST_VALID: if (complete || expire) state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase

      if (!busy) begin
        if (wr_data)     data_q <= wd_data;
        else if (wr_set) data_q <= data_q | wd_data;
        else if (wr_clr) data_q <= data_q & ~wd_data;
      end

      if (wr_ctrl)    auto_q    <= writedata[CTRL_AUTO];
      if (wr_timeout) timeout_q <= writedata[TIMEOUT_WIDTH-1:0];

      // A set event on the same edge beats a write-1-to-clear.
      done_q <= complete | (done_q & ~(wr_status & writedata[STATUS_DONE]));
      tmo_q  <= expire   | (tmo_q  & ~(wr_status & writedata[STATUS_TMO]));
      ovr_q  <= overrun  | (ovr_q  & ~(wr_status & writedata[STATUS_OVR]));
    end
  end

`ifdef HPS_PIO_HANDSHAKE_IRQ_EN
  logic [2:0] irq_mask_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask_q <= '0;
      irq        <= 1'b0;
    end else begin
      if (wr && (address == ADDR_IRQ_MASK)) irq_mask_q <= writedata[3:1];
      irq <= |({ovr_q, tmo_q, done_q} & irq_mask_q);
    end
  end
`endif

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata = 32'(data_q);
      ADDR_CTRL:    readdata = {30'd0, auto_q, 1'b0};
      ADDR_STATUS:  readdata = {28'd0, ovr_q, tmo_q, done_q, busy};
      ADDR_TIMEOUT: readdata = 32'(timeout_q);
`ifdef HPS_PIO_HANDSHAKE_IRQ_EN
      ADDR_IRQ_MASK: readdata = {28'd0, irq_mask_q, 1'b0};
`endif
      default:      readdata = '0;
    endcase
  end

  assign out_data    = data_q;
  assign out_valid   = busy;
  assign unused_bits = ^{writedata, tmr_count, tmr_zero};

endmodule

// File: tb/tb_hps_pio_handshake.sv
// Directed bench for hps_pio_handshake: register-access vector table plus handshake/timeout sequences.
module tb_hps_pio_handshake;
  import hps_pio_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        in_ready = 1'b0;
`ifdef HPS_PIO_HANDSHAKE_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int errors = 0;

  hps_pio_handshake #(
    .DATA_WIDTH(8),
    .TIMEOUT_WIDTH(16)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .in_ready  (in_ready)
`ifdef HPS_PIO_HANDSHAKE_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cs;
    logic        wn;
    logic [2:0]  waddr;
    logic [31:0] wdata;
    logic [2:0]  raddr;
    logic [31:0] exp_rd;
    logic [7:0]  exp_od;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus(1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
    @(negedge clk);
    address = a;
    #1;
    check(name, readdata, exp);
  endtask

  initial begin
    int hi;

    vecs[0]  = '{1'b1, 1'b0, ADDR_DATA,    32'h5A,        ADDR_DATA,    32'h5A,   8'h5A};
    vecs[1]  = '{1'b1, 1'b0, ADDR_SET,     32'h81,        ADDR_DATA,    32'hDB,   8'hDB};
    vecs[2]  = '{1'b1, 1'b0, ADDR_CLR,     32'h0F,        ADDR_DATA,    32'hD0,   8'hD0};
    vecs[3]  = '{1'b1, 1'b0, ADDR_DATA,    32'h1FF,       ADDR_DATA,    32'hFF,   8'hFF};
    vecs[4]  = '{1'b0, 1'b0, ADDR_DATA,    32'h11,        ADDR_DATA,    32'hFF,   8'hFF};
    vecs[5]  = '{1'b1, 1'b1, ADDR_DATA,    32'h22,        ADDR_DATA,    32'hFF,   8'hFF};
    vecs[6]  = '{1'b1, 1'b0, ADDR_SET,     32'h00,        ADDR_SET,     32'h0,    8'hFF};
    vecs[7]  = '{1'b1, 1'b0, ADDR_CLR,     32'h00,        ADDR_CLR,     32'h0,    8'hFF};
    vecs[8]  = '{1'b1, 1'b0, ADDR_TIMEOUT, 32'h12345,     ADDR_TIMEOUT, 32'h2345, 8'hFF};
    vecs[9]  = '{1'b1, 1'b0, ADDR_CTRL,    32'h2,         ADDR_CTRL,    32'h2,    8'hFF};
    vecs[10] = '{1'b1, 1'b0, ADDR_CTRL,    32'h0,         ADDR_CTRL,    32'h0,    8'hFF};
    vecs[11] = '{1'b1, 1'b0, 3'd7,         32'hFFFFFFFF,  3'd7,         32'h0,    8'hFF};
    vecs[12] = '{1'b1, 1'b0, ADDR_STATUS,  32'hF,         ADDR_STATUS,  32'h0,    8'hFF};
    vecs[13] = '{1'b1, 1'b0, ADDR_TIMEOUT, 32'h0,         ADDR_TIMEOUT, 32'h0,    8'hFF};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) rd(3'(a), 32'h0, $sformatf("rst_reg%0d", a));

    // register access table
    for (int i = 0; i < 14; i++) begin
      bus(vecs[i].cs, vecs[i].wn, vecs[i].waddr, vecs[i].wdata);
      rd(vecs[i].raddr, vecs[i].exp_rd, $sformatf("vec%0d_rd", i));
      check($sformatf("vec%0d_od", i), 32'(out_data), 32'(vecs[i].exp_od));
      check($sformatf("vec%0d_ov", i), 32'(out_valid), 32'h0);
    end

    // handshake with in_ready after 3 cycles
    wr(ADDR_DATA, 32'hA5);
    wr(ADDR_CTRL, 32'h1);
    check("a_valid_launch", 32'(out_valid), 32'h1);
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) hi++;
      if (i == 0) check("a_out_data", 32'(out_data), 32'hA5);
      in_ready = (i == 2);
    end
    check("a_valid_cycles", 32'(hi), 32'd3);
    rd(ADDR_STATUS, 32'h2, "a_status");

    // timeout expiry
    wr(ADDR_TIMEOUT, 32'd4);
    wr(ADDR_STATUS, 32'hE);
    wr(ADDR_CTRL, 32'h1);
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) hi++;
    end
    check("b_valid_cycles", 32'(hi), 32'd4);
    rd(ADDR_STATUS, 32'h4, "b_status");

    // in_ready on the expiry edge
    wr(ADDR_STATUS, 32'hE);
    wr(ADDR_CTRL, 32'h1);
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) hi++;
      in_ready = (i == 3);
    end
    check("c_valid_cycles", 32'(hi), 32'd4);
    rd(ADDR_STATUS, 32'h2, "c_status");

    // DONE set beats a same-edge write-1-to-clear
    wr(ADDR_CTRL, 32'h1);
    in_ready = 1'b1;
    wr(ADDR_STATUS, 32'h2);
    in_ready = 1'b0;
    check("d_valid_done", 32'(out_valid), 32'h0);
    rd(ADDR_STATUS, 32'h2, "d_status_sticky");
    wr(ADDR_STATUS, 32'h2);
    rd(ADDR_STATUS, 32'h0, "d_status_cleared");

    // AUTO launch, overrun, relaunch via CLR; timeout disabled
    wr(ADDR_TIMEOUT, 32'h0);
    wr(ADDR_CTRL, 32'h2);
    wr(ADDR_DATA, 32'h0F);
    check("e_auto_valid", 32'(out_valid), 32'h1);
    check("e_auto_data", 32'(out_data), 32'h0F);
    wr(ADDR_SET, 32'hF0);
    check("e_ovr_data", 32'(out_data), 32'h0F);
    rd(ADDR_STATUS, 32'h9, "e_status_ovr");
    repeat (20) @(negedge clk);
    check("e_no_timeout", 32'(out_valid), 32'h1);
    in_ready = 1'b1;
    @(posedge clk);
    #1;
    in_ready = 1'b0;
    check("e_done_valid", 32'(out_valid), 32'h0);
    rd(ADDR_STATUS, 32'hA, "e_status_done");
    wr(ADDR_CLR, 32'h01);
    check("e_relaunch_valid", 32'(out_valid), 32'h1);
    check("e_relaunch_data", 32'(out_data), 32'h0E);
    in_ready = 1'b1;
    @(posedge clk);
    #1;
    in_ready = 1'b0;
    check("e_relaunch_done", 32'(out_valid), 32'h0);
    wr(ADDR_CTRL, 32'h0);
    wr(ADDR_STATUS, 32'hE);

`ifdef HPS_PIO_HANDSHAKE_IRQ_EN
    wr(ADDR_IRQ_MASK, 32'h2);
    rd(ADDR_IRQ_MASK, 32'h2, "f_mask_rd");
    check("f_irq_idle", 32'(irq), 32'h0);
    wr(ADDR_CTRL, 32'h1);
    in_ready = 1'b1;
    @(posedge clk);
    #1;
    in_ready = 1'b0;
    check("f_irq_lag", 32'(irq), 32'h0);
    @(posedge clk);
    #1;
    check("f_irq_rise", 32'(irq), 32'h1);
    wr(ADDR_STATUS, 32'h2);
    check("f_irq_hold", 32'(irq), 32'h1);
    @(posedge clk);
    #1;
    check("f_irq_fall", 32'(irq), 32'h0);
`else
    wr(ADDR_IRQ_MASK, 32'hE);
    rd(ADDR_IRQ_MASK, 32'h0, "f_addr6_rd");
`endif

    // reset mid-transfer
    wr(ADDR_DATA, 32'h77);
    wr(ADDR_TIMEOUT, 32'd9);
    wr(ADDR_CTRL, 32'h3);
    check("g_valid_before", 32'(out_valid), 32'h1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("g_valid_async", 32'(out_valid), 32'h0);
    check("g_data_async", 32'(out_data), 32'h0);
`ifdef HPS_PIO_HANDSHAKE_IRQ_EN
    check("g_irq_async", 32'(irq), 32'h0);
`endif
    for (int a = 0; a < 8; a++) rd(3'(a), 32'h0, $sformatf("g_reg%0d", a));
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("g_valid_after", 32'(out_valid), 32'h0);
    rd(ADDR_STATUS, 32'h0, "g_status_after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
